// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite types for the command master and its benches.
package axi_lite_pkg;

    typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RSP} state_t;

    // Structs are sized for the widest legal configuration; narrower masters use the low bits.
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_LAT_W  = 16;

    typedef struct packed {
        logic                    write;
        logic [MAX_ADDR_W-1:0]   addr;
        logic [MAX_DATA_W-1:0]   wdata;
        logic [MAX_DATA_W/8-1:0] wstrb;
    } cmd_t;

    typedef struct packed {
        logic                  write;
        logic [MAX_DATA_W-1:0] rdata;
        resp_t                 resp;
        logic [MAX_LAT_W-1:0]  lat;
    } rsp_t;

endpackage

// File: rtl/axi_lite_sat_counter.sv
// axi_lite_sat_counter: clearable up-counter that sticks at its all-ones value.
module axi_lite_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (en_i && count_q != '1)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite master fed by a command stream,
// returning data, response code and latency on a handshaked response stream.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 8,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [LAT_W-1:0]  rsp_lat,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              write_q, write_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t             rsp_resp_q, rsp_resp_d;
    logic              awvalid_q, wvalid_q, arvalid_q, rready_q, bready_q, rsp_valid_q;
    logic              lat_clear;
    logic              lat_en;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        lat_clear   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                write_d   = cmd_write;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                lat_clear = 1'b1;
                state_d   = cmd_write ? WRITE : RADDR;
            end
            RADDR: if (arready) state_d = RDATA;
            RDATA: if (rvalid) begin
                rsp_rdata_d = rdata;
                rsp_resp_d  = resp_t'(rresp);
                state_d     = RSP;
            end
            WRITE: begin
                if (awvalid_q && awready) aw_done_d = 1'b1;
                if (wvalid_q && wready) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) state_d = WRESP;
            end
            WRESP: if (bvalid) begin
                rsp_rdata_d = '0;
                rsp_resp_d  = resp_t'(bresp);
                state_d     = RSP;
            end
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valid/ready outputs are registered by decoding the next state.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awvalid_q   <= (state_d == WRITE) && !aw_done_d;
            wvalid_q    <= (state_d == WRITE) && !w_done_d;
            arvalid_q   <= (state_d == RADDR);
            rready_q    <= (state_d == RDATA);
            bready_q    <= (state_d == WRESP);
            rsp_valid_q <= (state_d == RSP);
        end
    end

    // Count every edge after acceptance through the R/B handshake edge.
    assign lat_en = (state_q == RADDR) || (state_q == RDATA) || (state_q == WRITE) || (state_q == WRESP);

    axi_lite_sat_counter #(.WIDTH(LAT_W)) u_lat (
        .clk_i   (aclk),
        .rst_ni  (areset_n),
        .clear_i (lat_clear),
        .en_i    (lat_en),
        .count_o (rsp_lat)
    );

    assign cmd_ready = (state_q == IDLE) && areset_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awprot    = 3'b000;
    assign arprot    = 3'b000;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed checks of the command master; a LAT_W=4 twin
// shares all inputs to observe latency saturation.
module tb_axi_lite_cmd_master;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_ready = 1'b0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    logic        cmd_ready, rsp_valid, rsp_write, awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] rsp_rdata, wdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_lat;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;

    logic        s_cmd_ready, s_rsp_valid, s_rsp_write, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0] s_rsp_rdata, s_wdata;
    logic [1:0]  s_rsp_resp;
    logic [3:0]  s_rsp_lat;
    logic [11:0] s_awaddr, s_araddr;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_lite_cmd_master #(.ADDR_W(12), .DATA_W(32), .LAT_W(8)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_lat(rsp_lat),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    axi_lite_cmd_master #(.ADDR_W(12), .DATA_W(32), .LAT_W(4)) dut_sat (
        .aclk(aclk), .areset_n(areset_n),
        .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(s_rsp_write),
        .rsp_rdata(s_rsp_rdata), .rsp_resp(s_rsp_resp), .rsp_lat(s_rsp_lat),
        .awaddr(s_awaddr), .awprot(s_awprot), .awvalid(s_awvalid), .awready(awready),
        .wdata(s_wdata), .wstrb(s_wstrb), .wvalid(s_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(s_bready),
        .araddr(s_araddr), .arprot(s_arprot), .arvalid(s_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(s_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs then show the new cycle.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Reset
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_rsp_lat", rsp_lat, 0);
        step();
        step();
        areset_n = 1'b1;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("awprot", {awprot, arprot}, 0);

        // Minimum read
        arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h004;
        step();
        cmd_valid = 0;
        chk("rd_arvalid_c1", arvalid, 1);
        chk("rd_araddr", araddr, 12'h004);
        chk("rd_rready_c1", rready, 0);
        step();
        chk("rd_rready_c2", rready, 1);
        chk("rd_arvalid_c2", arvalid, 0);
        step();
        chk("rd_rsp_valid_c3", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_resp", rsp_resp, 0);
        chk("rd_lat", rsp_lat, 2);
        chk("rd_write", rsp_write, 0);
        chk("rd_cmd_ready_busy", cmd_ready, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("rd_cmd_ready_after", cmd_ready, 1);
        chk("rd_rsp_valid_after", rsp_valid, 0);
        arready = 0; rvalid = 0;

        // Write, W accepted three cycles before AW
        wready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h010; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'b0101;
        step();
        cmd_valid = 0;
        chk("wr_awvalid_c1", awvalid, 1);
        chk("wr_wvalid_c1", wvalid, 1);
        chk("wr_wstrb", wstrb, 4'b0101);
        chk("wr_wdata", wdata, 32'h1234_5678);
        chk("wr_awaddr", awaddr, 12'h010);
        step();
        wready = 0;
        chk("wr_wvalid_drop", wvalid, 0);
        chk("wr_awvalid_hold2", awvalid, 1);
        step();
        chk("wr_awvalid_hold3", awvalid, 1);
        step();
        chk("wr_awvalid_hold4", awvalid, 1);
        chk("wr_bready_early", bready, 0);
        awready = 1;
        step();
        awready = 0;
        chk("wr_awvalid_drop", awvalid, 0);
        chk("wr_bready", bready, 1);
        bvalid = 1; bresp = 0;
        step();
        bvalid = 0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_write", rsp_write, 1);
        chk("wr_rsp_rdata_zero", rsp_rdata, 0);
        chk("wr_lat", rsp_lat, 5);
        chk("wr_single_b", bready, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Slow read with SLVERR, then response backpressure
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h0A8;
        step();
        cmd_valid = 0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("slow_arvalid_c%0d", i), arvalid, 1);
            step();
        end
        arready = 1;
        chk("slow_arvalid_c6", arvalid, 1);
        step();
        arready = 0;
        for (int i = 7; i <= 10; i++) begin
            chk($sformatf("slow_rready_c%0d", i), rready, 1);
            step();
        end
        rvalid = 1; rresp = 2; rdata = 32'h0BAD_F00D;
        step();
        rvalid = 0; rresp = 0;
        chk("slow_resp", rsp_resp, 2);
        chk("slow_lat", rsp_lat, 11);
        chk("slow_rdata", rsp_rdata, 32'h0BAD_F00D);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h0C0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_stable", {rsp_valid, rsp_resp, rsp_lat, rsp_rdata}, {1'b1, 2'd2, 8'd11, 32'h0BAD_F00D});
            step();
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("bp_cmd_ready_next", cmd_ready, 1);
        chk("bp_not_accepted_yet", arvalid, 0);
        arready = 1; rvalid = 1; rdata = 32'hCAFE_0001; rresp = 0;
        step();
        cmd_valid = 0;
        chk("bp_araddr", araddr, 12'h0C0);
        step();
        step();
        chk("bp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("bp_lat", rsp_lat, 2);
        rsp_ready = 1;
        step();
        rsp_ready = 0; arready = 0; rvalid = 0;

        // Reset in the middle of a write
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h020; cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'hF;
        step();
        cmd_valid = 0;
        step();
        chk("mid_awvalid_pre", awvalid, 1);
        areset_n = 0;
        #1;
        chk("mid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
        chk("mid_awaddr", awaddr, 0);
        #2;
        areset_n = 1;
        #1;
        chk("mid_idle", cmd_ready, 1);
        wready = 1; awready = 1; bvalid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_rsp", {rsp_valid, awvalid}, 0);
        end
        wready = 0; awready = 0; bvalid = 0;
        arready = 1; rvalid = 1; rdata = 32'h0000_55AA; rresp = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h030;
        step();
        cmd_valid = 0;
        step();
        step();
        chk("post_rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_lat}, {1'b1, 1'b0, 2'd1, 8'd2});
        chk("post_rst_rdata", rsp_rdata, 32'h0000_55AA);
        rsp_ready = 1;
        step();
        rsp_ready = 0; arready = 0; rvalid = 0;

        // Latency saturation with a 20-cycle B delay
        awready = 1; wready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h040; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
        step();
        cmd_valid = 0;
        step();
        awready = 0; wready = 0;
        chk("sat_bready", s_bready, 1);
        repeat (20) step();
        bvalid = 1; bresp = 3;
        step();
        bvalid = 0; bresp = 0;
        chk("sat_rsp_valid", s_rsp_valid, 1);
        chk("sat_lat4", s_rsp_lat, 15);
        chk("sat_lat8", rsp_lat, 22);
        chk("sat_resp", rsp_resp, 3);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("sat_idle", {cmd_ready, s_cmd_ready}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Parametrised AXI4-Lite master driven by a command/response stream. It accepts one read or write command at a time, issues AW and W concurrently, and returns read data, the slave's response code and the transaction latency on a response stream with its own handshake. It is the next-generation master for the interconnect test environment: it replaces the fixed 12-bit, zero-strobe, start-pulse master and adds backpressure on both the command and response sides.

## Interface
Parameters:
- ADDR_W, 12: address width in bits.
- DATA_W, 32: data width in bits. Legal values are 32 and 64. STRB_W = DATA_W/8.
- LAT_W, 8: width of the latency counter. The counter saturates.

Ports:
- aclk  in  1  the single clock.
- areset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  STRB_W  byte strobes, passed through unchanged.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  captured RDATA; 0 for writes.
- rsp_resp  out  2  captured RRESP or BRESP.
- rsp_lat  out  LAT_W  clock edges from command acceptance to the R or B handshake.
- AXI4-Lite master channels:
  - awaddr, awprot (tied 3'b000), awvalid, awready
  - wdata, wstrb, wvalid, wready
  - bresp, bvalid, bready
  - araddr, arprot (tied 3'b000), arvalid, arready
  - rdata, rresp, rvalid, rready
  - Widths follow ADDR_W and DATA_W.

## Operation
- States: IDLE, RADDR, RDATA, WRITE, WRESP, RSP.
- IDLE:
  - cmd_ready = 1 while areset_n is high.
  - On acceptance, the address, data, strobe and write flag are registered and the latency counter is cleared.
  - The next state is WRITE or RADDR.
- RADDR: arvalid = 1 and araddr = the latched address. On arvalid && arready, go to RDATA.
- RDATA: rready = 1. On rvalid, capture rdata and rresp and go to RSP.
- WRITE:
  - awvalid and wvalid are both asserted in the first WRITE cycle.
  - Each channel drops its valid on the cycle after its own handshake, tracked by separate aw_done and w_done flags.
  - The block moves to WRESP when both are done. This includes both handshakes on the same edge, and W completing before AW.
- WRESP: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0 and go to RSP.
- RSP: rsp_valid = 1, with the response fields held stable. On rsp_ready, go to IDLE.
- A valid is never withdrawn before its ready, and addr/data/strb are stable while valid is high.
- bready is low outside WRESP and rready is low outside RDATA. A bvalid or rvalid arriving early is simply not accepted.
- The latency counter increments on every edge from acceptance up to and including the R/B handshake edge, saturating at 2^LAT_W-1.
- Non-zero RRESP/BRESP values are not errors to this block; they are reported in rsp_resp as received.

## Timing
- Reset (asynchronous assertion):
  - The state is forced to IDLE.
  - All valid and ready outputs go to 0, including cmd_ready while reset is held.
  - awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_lat and rsp_write go to 0.
  - An in-flight transaction and any pending response are discarded.
- All outputs except cmd_ready are registered. cmd_ready = (state == IDLE) && areset_n.
- Minimum read with ready slaves:
  - Acceptance at edge 0.
  - arvalid high in cycle 1; AR handshake at edge 1.
  - rready high in cycle 2; R handshake at edge 2.
  - rsp_valid high in cycle 3, with rsp_lat = 2.
- Minimum write has the same schedule: AW and W handshake together at edge 1, B at edge 2, rsp_valid in cycle 3, rsp_lat = 2.
- Back-to-back throughput: after rsp_ready is seen at edge N, cmd_ready is high in cycle N+1. One transaction is in flight at a time.

## Structure
- axi_lite_pkg gains:
  - resp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - The master state enum.
  - A parametrised cmd/rsp struct for bench reuse.
- Sub-module axi_lite_sat_counter (WIDTH, clear, enable, saturating) implements rsp_lat.

## Test plan
- Read, addr 12'h004, arready/rvalid tied 1, rdata 32'hDEAD_BEEF -> rsp_rdata DEADBEEF, rsp_resp 0, rsp_lat 2, rsp_valid in cycle 3.
- Write, addr 12'h010, data 32'h1234_5678, strb 4'b0101, wready 3 cycles before awready -> wstrb 4'b0101 on the bus, wvalid drops after its handshake while awvalid stays high, single B accepted, rsp_write 1.
- Read with arready delayed 5 cycles, rvalid delayed 4 cycles and rresp=2 -> rsp_resp 2, rsp_lat 11, arvalid held continuously for the 5-cycle delay.
- rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready 0, and a new cmd_valid is not accepted until the cycle after rsp_ready.
- areset_n pulsed low during WRITE with awvalid high -> all valids 0 in the same cycle, state IDLE, no rsp_valid afterwards, and the next read completes normally.
- LAT_W=4 with a 20-cycle bvalid delay -> rsp_lat saturates at 15.
